// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction
// memory port and offers captured instructions to decode over valid/ready.
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] HALT_INSTR = 32'h00000063
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [63:0] PC_LIMIT = 64'(IMEM_WORDS) << 2;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic        valid_n;
    logic [31:0] instr_n;
    logic [63:0] opc_n;
    logic [31:0] count_n;
    logic        accept;
    logic        redirect_bad;

    assign accept       = !out_valid || out_ready;
    assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= PC_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= 32'h0;
            out_pc      <= 64'h0;
            fetch_count <= 32'h0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            out_valid   <= valid_n;
            out_instr   <= instr_n;
            out_pc      <= opc_n;
            fetch_count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = out_instr;
        opc_n   = out_pc;
        count_n = fetch_count;
        // A held instruction leaves only when decode takes it.
        valid_n = out_valid && !out_ready;

        unique case (state)
            S_RUN: begin
                if (redirect_valid) begin
                    valid_n = 1'b0;
                    if (redirect_bad) state_n = S_FAULT;
                    else              pc_n    = redirect_pc;
                end else if (pc >= PC_LIMIT) begin
                    state_n = S_FAULT;
                end else if (accept) begin
                    instr_n = imem_instr;
                    opc_n   = pc;
                    valid_n = 1'b1;
                    if (fetch_count != 32'hFFFF_FFFF) count_n = fetch_count + 32'd1;
                    if (imem_instr == HALT_INSTR) state_n = S_HALT;
                    else                          pc_n    = pc + 64'd4;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    valid_n = 1'b0;
                    if (redirect_bad) begin
                        state_n = S_FAULT;
                    end else begin
                        pc_n    = redirect_pc;
                        state_n = S_RUN;
                    end
                end
            end
            S_FAULT: begin
            end
            default: state_n = S_FAULT;
        endcase
    end

    assign imem_pc = pc;
    assign halted  = (state == S_HALT);
    assign fault   = (state == S_FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural instruction memory plus a
// scoreboard of expected (pc, instr) transfers to decode.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    localparam logic [31:0] W0  = 32'h00003083;
    localparam logic [31:0] W1  = 32'h00103103;
    localparam logic [31:0] HLT = 32'h00000063;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:255];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_pc[9:2]];

    fetch_stage #(
        .RESET_PC(64'h0),
        .IMEM_WORDS(256),
        .HALT_INSTR(32'h00000063)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_pc(imem_pc),
        .imem_instr(imem_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halted(halted),
        .fault(fault),
        .fetch_count(fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (imem_pc !== 64'h0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 64'h0 ||
            halted !== 1'b0 || fault !== 1'b0 || fetch_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h v=%b instr=%h opc=%h h=%b f=%b cnt=%0d, want all zero",
                     imem_pc, out_valid, out_instr, out_pc, halted, fault, fetch_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_halt();
        exp_t e;
        do_reset();
        out_ready = 1'b1;
        sb.push_back('{64'h0, W0});
        sb.push_back('{64'h4, W1});
        sb.push_back('{64'h8, HLT});
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_latency: out_valid=%b want 1", out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL basic_extra_xfer: pc=%h instr=%h, want none", out_pc, out_instr);
                end else begin
                    e = sb.pop_front();
                    if (out_pc !== e.pc || out_instr !== e.instr) begin
                        n_fail++;
                        $display("FAIL basic_xfer: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr);
                    end
                end
            end
            tick();
        end
        n_checks++;
        if (sb.size() != 0 || halted !== 1'b1 || imem_pc !== 64'h8 || fetch_count !== 32'd3 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_halt_end: left=%0d h=%b pc=%h cnt=%0d v=%b, want 0 1 8 3 0",
                     sb.size(), halted, imem_pc, fetch_count, out_valid);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        do_reset();
        out_ready = 1'b0;
        sb.push_back('{64'h0, W0});
        sb.push_back('{64'h4, W1});
        sb.push_back('{64'h8, HLT});
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_instr !== W0 || out_pc !== 64'h0 || imem_pc !== 64'h4 || fetch_count !== 32'd1) begin
                n_fail++;
                $display("FAIL stall_hold: v=%b instr=%h opc=%h pc=%h cnt=%0d, want 1 %h 0 4 1",
                         out_valid, out_instr, out_pc, imem_pc, fetch_count, W0);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL stall_extra_xfer: pc=%h instr=%h, want none", out_pc, out_instr);
                end else begin
                    e = sb.pop_front();
                    if (out_pc !== e.pc || out_instr !== e.instr) begin
                        n_fail++;
                        $display("FAIL stall_xfer: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr);
                    end
                end
            end
            tick();
        end
        n_checks++;
        if (sb.size() != 0 || fetch_count !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_resume: left=%0d cnt=%0d, want 0 3", sb.size(), fetch_count);
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        do_reset();
        out_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h4;
        sb.push_back('{64'h4, W1});
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || fetch_count !== 32'd1 || imem_pc !== 64'h4) begin
            n_fail++;
            $display("FAIL redirect_flush: v=%b cnt=%0d pc=%h, want 0 1 4", out_valid, fetch_count, imem_pc);
        end
        tick();
        n_checks++;
        if (!(out_valid && out_ready) || sb.size() == 0) begin
            n_fail++;
            $display("FAIL redirect_no_capture: v=%b left=%0d, want 1 1", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if (out_pc !== e.pc || out_instr !== e.instr || fetch_count !== 32'd2) begin
                n_fail++;
                $display("FAIL redirect_capture: got %h/%h cnt=%0d want %h/%h cnt=2",
                         out_pc, out_instr, fetch_count, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        out_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h6;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || out_valid !== 1'b0 || fetch_count !== 32'd1) begin
            n_fail++;
            $display("FAIL misaligned_fault: f=%b v=%b cnt=%0d, want 1 0 1", fault, out_valid, fetch_count);
        end
        for (int i = 0; i < 5; i++) begin
            redirect_valid = (i == 2);
            redirect_pc = 64'h0;
            tick();
        end
        redirect_valid = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || out_valid !== 1'b0 || fetch_count !== 32'd1 || imem_pc !== 64'h4) begin
            n_fail++;
            $display("FAIL fault_sticky: f=%b v=%b cnt=%0d pc=%h, want 1 0 1 4", fault, out_valid, fetch_count, imem_pc);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_reset_clear: f=%b want 0", fault);
        end
    endtask

    task automatic test_range_and_halt_redirect();
        exp_t e;
        do_reset();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h400;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (fault !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL range_fault: f=%b v=%b, want 1 0", fault, out_valid);
        end

        // Last valid word, then sequential step off the end of memory.
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 64'h3FC;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (fault !== 1'b0 || imem_pc !== 64'h3FC) begin
            n_fail++;
            $display("FAIL last_word_redirect: f=%b pc=%h, want 0 3fc", fault, imem_pc);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h3FC || out_instr !== NOP || imem_pc !== 64'h400) begin
            n_fail++;
            $display("FAIL last_word_capture: v=%b opc=%h instr=%h pc=%h", out_valid, out_pc, out_instr, imem_pc);
        end
        tick();
        n_checks++;
        if (fault !== 1'b1 || out_valid !== 1'b0 || fetch_count !== 32'd1) begin
            n_fail++;
            $display("FAIL seq_range_fault: f=%b v=%b cnt=%0d, want 1 0 1", fault, out_valid, fetch_count);
        end

        do_reset();
        for (int i = 0; i < 20 && !(halted && !out_valid); i++) tick();
        n_checks++;
        if (!(halted === 1'b1 && out_valid === 1'b0)) begin
            n_fail++;
            $display("FAIL halt_timeout: h=%b v=%b, want 1 0", halted, out_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h8;
        sb.push_back('{64'h8, HLT});
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (halted !== 1'b0 || out_valid !== 1'b0 || imem_pc !== 64'h8) begin
            n_fail++;
            $display("FAIL halt_redirect: h=%b v=%b pc=%h, want 0 0 8", halted, out_valid, imem_pc);
        end
        tick();
        n_checks++;
        if (!(out_valid && out_ready) || sb.size() == 0) begin
            n_fail++;
            $display("FAIL halt_recapture_missing: v=%b left=%0d", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            if (out_pc !== e.pc || out_instr !== e.instr || halted !== 1'b1 || fetch_count !== 32'd4) begin
                n_fail++;
                $display("FAIL halt_recapture: got %h/%h h=%b cnt=%0d want %h/%h h=1 cnt=4",
                         out_pc, out_instr, halted, fetch_count, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8;
        tick();
        n_checks++;
        if (imem_pc !== 64'h0 || out_valid !== 1'b0 || fetch_count !== 32'h0 || halted !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_stream: pc=%h v=%b cnt=%0d h=%b f=%b, want 0 0 0 0 0",
                     imem_pc, out_valid, fetch_count, halted, fault);
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        mem[0] = W0;
        mem[1] = W1;
        mem[2] = HLT;
        rst = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;

        test_reset();
        test_basic_halt();
        test_stall();
        test_redirect();
        test_misaligned();
        test_range_and_halt_redirect();
        test_reset_mid_stream();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
